// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Brief    : Shared types, policy constants and address-field helpers for the
//            set-associative data cache.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  // Refill sequencer states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWAP_OUT   = 2'd1,
    SWAP_IN    = 2'd2,
    SWAP_IN_OK = 2'd3
  } cacheState_e;

  localparam int REPLACE_FIFO = 0;
  localparam int REPLACE_LRU  = 1;

  // Tag width left over once word offset, set index and byte offset are removed
  function automatic int tagAddrLen(input int lineAddrLen, input int setAddrLen);
    return 32 - 2 - lineAddrLen - setAddrLen;
  endfunction

  // Way index width; a direct-mapped cache still carries a 1-bit index
  function automatic int wayIdxLen(input int wayCnt);
    return (wayCnt > 1) ? $clog2(wayCnt) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_setassoc_repl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_repl
// Brief    : Per-set replacement state (FIFO pointer or LRU ages) and victim
//            way selection. Empty for a direct-mapped cache.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_repl
  import dcache_pkg::*;
#(
  parameter int  SET_ADDR_LEN   = 4,
  parameter int  WAY_CNT        = 2,
  parameter int  REPLACE_POLICY = REPLACE_FIFO,
  localparam int WAY_W          = wayIdxLen(WAY_CNT)
) (
  input  logic                    clk,
  input  logic                    rst,          // asynchronous, active-low
  input  logic [SET_ADDR_LEN-1:0] set,
  input  logic [WAY_W-1:0]        access_way,
  input  logic                    access_en,
  input  logic                    fill_en,
  output logic [WAY_W-1:0]        victim_way
);

  localparam int SETS = 2 ** SET_ADDR_LEN;

  generate
    if (WAY_CNT == 1) begin : g_direct
      logic w_unusedRepl;
      assign w_unusedRepl = ^{clk, rst, set, access_way, access_en, fill_en};
      assign victim_way   = '0;
    end else if (REPLACE_POLICY == REPLACE_LRU) begin : g_lru
      localparam logic [WAY_W-1:0] C_MAX_AGE = WAY_W'(WAY_CNT - 1);
      logic [WAY_W-1:0] r_age [SETS][WAY_CNT];
      logic [WAY_W-1:0] w_oldest;
      logic             w_unusedRepl;
      assign w_unusedRepl = fill_en;

      // Touched way becomes age 0; ways no older than it age by one. Equal
      // ages (only after reset) count as younger so the ages settle into a
      // permutation once every way has been touched.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAY_CNT; w++)
              r_age[s][w] <= '0;
        end else if (access_en) begin
          for (int w = 0; w < WAY_CNT; w++) begin
            if (WAY_W'(w) == access_way)
              r_age[set][w] <= '0;
            else if ((r_age[set][w] <= r_age[set][access_way]) && (r_age[set][w] != C_MAX_AGE))
              r_age[set][w] <= r_age[set][w] + 1'b1;
          end
        end
      end

      // Oldest way is the victim; the lowest index wins a tie
      always_comb begin
        victim_way = '0;
        w_oldest   = r_age[set][0];
        for (int w = 1; w < WAY_CNT; w++) begin
          if (r_age[set][w] > w_oldest) begin
            victim_way = WAY_W'(w);
            w_oldest   = r_age[set][w];
          end
        end
      end
    end else begin : g_fifo
      logic [WAY_W-1:0] r_ptr [SETS];
      logic             w_unusedRepl;
      assign w_unusedRepl = ^{access_way, access_en};

      // Round-robin pointer advances on every fill of the set; wraps naturally
      // because the way count is a power of two
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
        end else if (fill_en) begin
          r_ptr[set] <= r_ptr[set] + 1'b1;
        end
      end

      assign victim_way = r_ptr[set];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dcache_setassoc.sv
`default_nettype none
// ============================================================================
// Module   : dcache_setassoc
// Brief    : Write-back, write-allocate set-associative data cache. Hits are
//            served in the issuing cycle; misses stall the core through `miss`
//            while the victim is written back and the line is refilled.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_setassoc
  import dcache_pkg::*;
#(
  parameter int  LINE_ADDR_LEN  = 3,
  parameter int  SET_ADDR_LEN   = 4,
  parameter int  TAG_ADDR_LEN   = tagAddrLen(LINE_ADDR_LEN, SET_ADDR_LEN),
  parameter int  WAY_CNT        = 2,
  parameter int  REPLACE_POLICY = REPLACE_FIFO,
  localparam int LINE_W         = 32 * (2 ** LINE_ADDR_LEN)
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [31:0]       addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be,
  output logic [31:0]       rd_data,
  output logic              miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wline,
  input  logic [LINE_W-1:0] mem_rline,
  input  logic              mem_ready,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int WAY_W = wayIdxLen(WAY_CNT);
  localparam int SETS  = 2 ** SET_ADDR_LEN;

  logic [TAG_ADDR_LEN-1:0]  w_tag;
  logic [SET_ADDR_LEN-1:0]  w_set;
  logic [LINE_ADDR_LEN-1:0] w_word;
  logic                     w_unusedAddr;

  assign w_tag        = addr[31 -: TAG_ADDR_LEN];
  assign w_set        = addr[31-TAG_ADDR_LEN -: SET_ADDR_LEN];
  assign w_word       = addr[LINE_ADDR_LEN+1:2];
  assign w_unusedAddr = ^addr[1:0];

  logic [LINE_W-1:0]       r_lineMem [SETS][WAY_CNT];
  logic [TAG_ADDR_LEN-1:0] r_tagMem  [SETS][WAY_CNT];
  logic [WAY_CNT-1:0]      r_valid   [SETS];
  logic [WAY_CNT-1:0]      r_dirty   [SETS];
  cacheState_e             r_state;
  logic [WAY_W-1:0]        r_victim;
  logic [31:0]             r_hitCnt;
  logic [31:0]             r_missCnt;

  logic              w_req, w_wayHit, w_hit, w_fill, w_freeFound;
  logic [WAY_W-1:0]  w_hitWay, w_freeWay, w_replWay, w_victimWay;
  logic [LINE_W-1:0] w_hitLine, w_storeLine;
  logic [31:0]       w_oldWord, w_newWord;

  // Tag compare across the ways of the addressed set, plus lowest free way
  always_comb begin
    w_wayHit    = 1'b0;
    w_hitWay    = '0;
    w_freeFound = 1'b0;
    w_freeWay   = '0;
    for (int w = WAY_CNT - 1; w >= 0; w--) begin
      if (r_valid[w_set][w] && (r_tagMem[w_set][w] == w_tag)) begin
        w_wayHit = 1'b1;
        w_hitWay = WAY_W'(w);
      end
      if (!r_valid[w_set][w]) begin
        w_freeFound = 1'b1;
        w_freeWay   = WAY_W'(w);
      end
    end
  end

  assign w_req       = rd_req | wr_req;
  assign w_hit       = w_req & (r_state == IDLE) & w_wayHit;
  assign w_fill      = (r_state == SWAP_IN) & mem_ready;
  assign w_victimWay = w_freeFound ? w_freeWay : w_replWay;
  assign miss        = (w_req & ~w_hit) | (r_state != IDLE);

  assign w_hitLine = r_lineMem[w_set][w_hitWay];
  assign w_oldWord = w_hitLine[{w_word, 5'b0} +: 32];
  assign rd_data   = w_oldWord;

  // Byte-lane merge of the store into the hit line
  always_comb begin
    w_newWord = w_oldWord;
    for (int b = 0; b < 4; b++)
      if (wr_be[b]) w_newWord[b*8 +: 8] = wr_data[b*8 +: 8];
    w_storeLine = w_hitLine;
    w_storeLine[{w_word, 5'b0} +: 32] = w_newWord;
  end

  dcache_repl #(
    .SET_ADDR_LEN   (SET_ADDR_LEN),
    .WAY_CNT        (WAY_CNT),
    .REPLACE_POLICY (REPLACE_POLICY)
  ) u_repl (
    .clk        (clk),
    .rst        (rst),
    .set        (w_set),
    .access_way (w_fill ? r_victim : w_hitWay),
    .access_en  (w_hit | w_fill),
    .fill_en    (w_fill),
    .victim_way (w_replWay)
  );

  // Refill sequencer, valid/dirty bookkeeping and hit/miss counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_victim  <= '0;
      r_hitCnt  <= '0;
      r_missCnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
    end else begin
      if (w_hit) begin
        r_hitCnt <= r_hitCnt + 32'd1;
        if (wr_req) r_dirty[w_set][w_hitWay] <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_req && !w_wayHit) begin
            r_victim  <= w_victimWay;
            r_missCnt <= r_missCnt + 32'd1;
            r_state   <= (r_valid[w_set][w_victimWay] && r_dirty[w_set][w_victimWay])
                         ? SWAP_OUT : SWAP_IN;
          end
        end
        SWAP_OUT: if (mem_ready) r_state <= SWAP_IN;
        SWAP_IN: begin
          if (mem_ready) begin
            r_valid[w_set][r_victim] <= 1'b1;
            r_dirty[w_set][r_victim] <= 1'b0;
            r_state                  <= SWAP_IN_OK;
          end
        end
        SWAP_IN_OK: r_state <= IDLE;
        default:    r_state <= IDLE;
      endcase
    end
  end

  // Line data and tags carry no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_lineMem[w_set][r_victim] <= mem_rline;
      r_tagMem[w_set][r_victim]  <= w_tag;
    end else if (w_hit && wr_req) begin
      r_lineMem[w_set][w_hitWay] <= w_storeLine;
    end
  end

  // Memory-side request decode from the sequencer state
  always_comb begin
    mem_req  = (r_state == SWAP_OUT) || (r_state == SWAP_IN);
    mem_we   = (r_state == SWAP_OUT);
    mem_addr = '0;
    if (r_state == SWAP_OUT)
      mem_addr = {r_tagMem[w_set][r_victim], w_set, {(LINE_ADDR_LEN+2){1'b0}}};
    else if (r_state == SWAP_IN)
      mem_addr = {w_tag, w_set, {(LINE_ADDR_LEN+2){1'b0}}};
  end

  assign mem_wline = r_lineMem[w_set][r_victim];
  assign hit_cnt   = r_hitCnt;
  assign miss_cnt  = r_missCnt;

endmodule
`default_nettype wire

// File: tb/tb_dcache_setassoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_setassoc
// Brief    : Directed self-checking bench. Two cache instances (2-way LRU and
//            2-way FIFO) share one stimulus bus and one memory model; `sel`
//            routes requests and mem_ready to exactly one of them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_setassoc;

  localparam int MEM_LAT = 3;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        rdReq, wrReq;
  logic [31:0] addr, wrData;
  logic [3:0]  wrBe;
  logic        memReady;
  logic [255:0] memRline;

  logic [31:0]  rdDataA, rdDataB, memAddrA, memAddrB;
  logic [31:0]  hitCntA, hitCntB, missCntA, missCntB;
  logic         missA, missB, memReqA, memReqB, memWeA, memWeB;
  logic [255:0] memWlineA, memWlineB;

  logic [31:0]  rdData, memAddr, hitCnt, missCnt;
  logic         miss, memReq, memWe;
  logic [255:0] memWline;

  assign rdData   = sel ? rdDataB   : rdDataA;
  assign memAddr  = sel ? memAddrB  : memAddrA;
  assign hitCnt   = sel ? hitCntB   : hitCntA;
  assign missCnt  = sel ? missCntB  : missCntA;
  assign miss     = sel ? missB     : missA;
  assign memReq   = sel ? memReqB   : memReqA;
  assign memWe    = sel ? memWeB    : memWeA;
  assign memWline = sel ? memWlineB : memWlineA;

  dcache_setassoc #(.WAY_CNT(2), .REPLACE_POLICY(1)) dutLru (
    .clk(clk), .rst(rst), .rd_req(rdReq & ~sel), .wr_req(wrReq & ~sel),
    .addr(addr), .wr_data(wrData), .wr_be(wrBe), .rd_data(rdDataA),
    .miss(missA), .mem_req(memReqA), .mem_we(memWeA), .mem_addr(memAddrA),
    .mem_wline(memWlineA), .mem_rline(memRline), .mem_ready(memReady & ~sel),
    .hit_cnt(hitCntA), .miss_cnt(missCntA)
  );

  dcache_setassoc #(.WAY_CNT(2), .REPLACE_POLICY(0)) dutFifo (
    .clk(clk), .rst(rst), .rd_req(rdReq & sel), .wr_req(wrReq & sel),
    .addr(addr), .wr_data(wrData), .wr_be(wrBe), .rd_data(rdDataB),
    .miss(missB), .mem_req(memReqB), .mem_we(memWeB), .mem_addr(memAddrB),
    .mem_wline(memWlineB), .mem_rline(memRline), .mem_ready(memReady & sel),
    .hit_cnt(hitCntB), .miss_cnt(missCntB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 512 lines of 8 words, fixed latency, records transactions
  logic [255:0] memArr [512];
  int           fillCnt, wbCnt;
  logic [31:0]  lastFillAddr, lastWbAddr;
  logic [255:0] lastWbLine;

  assign memRline = memArr[memAddr[13:5]];

  initial begin
    int pend;
    pend = 0; memReady = 1'b0; fillCnt = 0; wbCnt = 0;
    lastFillAddr = '0; lastWbAddr = '0; lastWbLine = '0;
    for (int i = 0; i < 512; i++)
      for (int k = 0; k < 8; k++)
        memArr[i][k*32 +: 32] = 32'hD000_0000 | (32'(i) << 8) | 32'(k);
    memArr[2][31:0]  = 32'h1234_5678;
    memArr[2][63:32] = 32'h1234_5678;
    forever begin
      @(posedge clk); #1;
      memReady = 1'b0;
      if (memReq) begin
        pend++;
        if (pend == MEM_LAT) begin
          pend = 0;
          memReady = 1'b1;
          if (memWe) begin
            wbCnt++;
            lastWbAddr = memAddr;
            lastWbLine = memWline;
            memArr[memAddr[13:5]] = memWline;
          end else begin
            fillCnt++;
            lastFillAddr = memAddr;
          end
        end
      end else begin
        pend = 0;
      end
    end
  end

  int testsRun, testsFailed;

  task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one access, wait out any stall, sample the hit-cycle read data and
  // let the hit commit at the following edge.
  task automatic doAccess(input logic isWr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int stalls, output logic [31:0] rdv);
    addr = a; wrData = d; wrBe = be;
    rdReq = ~isWr; wrReq = isWr;
    stalls = 0;
    #1;
    while (miss && stalls < 40) begin
      tick();
      stalls++;
    end
    if (stalls >= 40) checkVal("access_timeout", 256'(stalls), 256'(0));
    rdv = rdData;
    tick();
    rdReq = 1'b0; wrReq = 1'b0;
  endtask

  initial begin
    int           stalls;
    logic [31:0]  rdv;
    logic [255:0] expLine;
    testsRun = 0; testsFailed = 0;
    sel = 1'b0; rdReq = 1'b0; wrReq = 1'b0; addr = '0; wrData = '0; wrBe = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("rst_miss",     256'(miss),    256'(0));
    checkVal("rst_mem_req",  256'(memReq),  256'(0));
    checkVal("rst_mem_we",   256'(memWe),   256'(0));
    checkVal("rst_mem_addr", 256'(memAddr), 256'(0));
    checkVal("rst_hit_cnt",  256'(hitCnt),  256'(0));
    checkVal("rst_miss_cnt", 256'(missCnt), 256'(0));
    rst = 1'b1;
    tick();

    // Cold read miss on a clean set
    doAccess(1'b0, 32'h40, 32'h0, 4'h0, stalls, rdv);
    checkVal("cold_stall",     256'(stalls),       256'(5));
    checkVal("cold_rdata",     256'(rdv),          256'(32'h1234_5678));
    checkVal("cold_fill_cnt",  256'(fillCnt),      256'(1));
    checkVal("cold_fill_addr", 256'(lastFillAddr), 256'(32'h40));
    checkVal("cold_miss_cnt",  256'(missCnt),      256'(1));
    checkVal("cold_hit_cnt",   256'(hitCnt),       256'(1));

    // Single byte-lane store hit
    doAccess(1'b1, 32'h44, 32'hAABB_CCDD, 4'b0010, stalls, rdv);
    checkVal("st_stall", 256'(stalls), 256'(0));
    doAccess(1'b0, 32'h44, 32'h0, 4'h0, stalls, rdv);
    checkVal("st_rdata", 256'(rdv), 256'(32'h1234_CC78));
    checkVal("st_dirty", 256'(dutLru.r_dirty[2][0]), 256'(1));

    // LRU dirty eviction: A=0x40 dirty, B=0x240 most recent, C=0x440 evicts A
    doAccess(1'b0, 32'h240, 32'h0, 4'h0, stalls, rdv);
    checkVal("b_fill_stall", 256'(stalls), 256'(5));
    doAccess(1'b1, 32'h40, 32'h1111_1111, 4'hF, stalls, rdv);
    checkVal("a_store_stall", 256'(stalls), 256'(0));
    doAccess(1'b0, 32'h244, 32'h0, 4'h0, stalls, rdv);
    checkVal("b_touch_stall", 256'(stalls), 256'(0));
    checkVal("b_touch_rdata", 256'(rdv),    256'(32'hD000_1201));
    doAccess(1'b0, 32'h444, 32'h0, 4'h0, stalls, rdv);
    for (int k = 0; k < 8; k++) expLine[k*32 +: 32] = 32'hD000_0200 | 32'(k);
    expLine[31:0]  = 32'h1111_1111;
    expLine[63:32] = 32'h1234_CC78;
    checkVal("c_stall",     256'(stalls),       256'(8));
    checkVal("c_wb_cnt",    256'(wbCnt),        256'(1));
    checkVal("c_wb_addr",   256'(lastWbAddr),   256'(32'h40));
    checkVal("c_wb_line",   lastWbLine,         expLine);
    checkVal("c_fill_addr", 256'(lastFillAddr), 256'(32'h440));
    checkVal("c_rdata",     256'(rdv),          256'(32'hD000_2201));
    doAccess(1'b0, 32'h240, 32'h0, 4'h0, stalls, rdv);
    checkVal("b_keep_stall", 256'(stalls), 256'(0));
    checkVal("b_keep_rdata", 256'(rdv),    256'(32'hD000_1200));

    // Hit counter wrap
    @(negedge clk);
    dutLru.r_hitCnt = 32'hFFFF_FFFF;
    tick();
    doAccess(1'b0, 32'h244, 32'h0, 4'h0, stalls, rdv);
    checkVal("wrap_stall",   256'(stalls), 256'(0));
    checkVal("wrap_hit_cnt", 256'(hitCnt), 256'(0));

    // FIFO: X=0x60, Y=0x260 fill set 3, X re-hit, Z=0x460 still evicts X
    sel = 1'b1;
    doAccess(1'b0, 32'h60, 32'h0, 4'h0, stalls, rdv);
    checkVal("fifo_x_stall", 256'(stalls), 256'(5));
    checkVal("fifo_x_rdata", 256'(rdv),    256'(32'hD000_0300));
    doAccess(1'b0, 32'h260, 32'h0, 4'h0, stalls, rdv);
    checkVal("fifo_y_stall", 256'(stalls), 256'(5));
    doAccess(1'b0, 32'h60, 32'h0, 4'h0, stalls, rdv);
    checkVal("fifo_x_hit", 256'(stalls), 256'(0));
    doAccess(1'b0, 32'h64, 32'h0, 4'h0, stalls, rdv);
    checkVal("fifo_x_hit2", 256'(stalls), 256'(0));
    doAccess(1'b0, 32'h460, 32'h0, 4'h0, stalls, rdv);
    checkVal("fifo_z_stall",     256'(stalls),       256'(5));
    checkVal("fifo_z_fill_addr", 256'(lastFillAddr), 256'(32'h460));
    doAccess(1'b0, 32'h260, 32'h0, 4'h0, stalls, rdv);
    checkVal("fifo_y_kept", 256'(stalls), 256'(0));
    doAccess(1'b0, 32'h60, 32'h0, 4'h0, stalls, rdv);
    checkVal("fifo_x_evicted", 256'(stalls),  256'(5));
    checkVal("fifo_miss_cnt",  256'(missCnt), 256'(4));
    checkVal("fifo_hit_cnt",   256'(hitCnt),  256'(7));

    // Reset while a fill is outstanding
    sel = 1'b0;
    addr = 32'h840; rdReq = 1'b1;
    tick();
    checkVal("pre_rst_mem_req",  256'(memReq),  256'(1));
    checkVal("pre_rst_mem_addr", 256'(memAddr), 256'(32'h840));
    #2 rst = 1'b0;
    #1;
    checkVal("mid_rst_mem_req",  256'(memReq),  256'(0));
    checkVal("mid_rst_mem_addr", 256'(memAddr), 256'(0));
    checkVal("mid_rst_hit_cnt",  256'(hitCnt),  256'(0));
    checkVal("mid_rst_miss_cnt", 256'(missCnt), 256'(0));
    rdReq = 1'b0;
    #1;
    checkVal("mid_rst_miss", 256'(miss), 256'(0));
    tick();
    rst = 1'b1;
    tick();
    doAccess(1'b0, 32'h840, 32'h0, 4'h0, stalls, rdv);
    checkVal("post_rst_stall",    256'(stalls),       256'(5));
    checkVal("post_rst_rdata",    256'(rdv),          256'(32'hD000_4200));
    checkVal("post_rst_fill",     256'(lastFillAddr), 256'(32'h840));
    checkVal("post_rst_miss_cnt", 256'(missCnt),      256'(1));
    checkVal("post_rst_hit_cnt",  256'(hitCnt),       256'(1));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/dcache_setassoc.md
Name: dcache_setassoc

Overview:
- Parametrised write-back, write-allocate, set-associative data cache for the RV32 pipeline core.
- Sits between the MEM-WB stage and main memory.
- Drives the core's DCacheMiss stall input: hits complete in the issuing cycle; misses stall the pipeline until the line refill finishes.
- Generalises the core's fixed single-cycle data RAM with configurable line size, set count, associativity and replacement policy, plus hit/miss counters.

Parameters:
- LINE_ADDR_LEN, 3: log2 of 32-bit words per line (line = 32*2^LINE_ADDR_LEN bits).
- SET_ADDR_LEN, 4: log2 of set count.
- TAG_ADDR_LEN, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN: tag width (derived).
- WAY_CNT, 2: ways per set; power of two, 1..8.
- REPLACE_POLICY, 0: 0 = FIFO, 1 = LRU.

Ports:
- clk, input, 1: core clock.
- rst, input, 1: asynchronous, active-low reset.
- rd_req, input, 1: load request from MEM-WB.
- wr_req, input, 1: store request from MEM-WB.
- addr, input, 32: byte address; bits [1:0] are ignored for word select.
- wr_data, input, 32: store data.
- wr_be, input, 4: store byte enables.
- rd_data, output, 32: load word, combinational on hit.
- miss, output, 1: stall to the hazard unit (DCacheMiss).
- mem_req, output, 1: memory transaction valid.
- mem_we, output, 1: 1 = line write-back, 0 = line fill.
- mem_addr, output, 32: line-aligned address.
- mem_wline, output, 32*2^LINE_ADDR_LEN: victim line data.
- mem_rline, input, 32*2^LINE_ADDR_LEN: fill line data.
- mem_ready, input, 1: one-cycle completion pulse for the current mem_req.
- hit_cnt, output, 32: number of hits.
- miss_cnt, output, 32: number of misses.

Behaviour:
- Address split: tag = addr[31 -: TAG_ADDR_LEN]; set = next SET_ADDR_LEN bits; word = addr[LINE_ADDR_LEN+1:2].
- Per-way state: valid, dirty, tag, line. Per-set state: replacement state.
- Hit = request asserted, state IDLE, and some way is valid with a matching tag. On a hit:
  - miss = 0.
  - A load returns the selected word combinationally.
  - A store writes the enabled bytes and sets dirty at the next posedge.
  - LRU: the hit way becomes most-recent.
- rd_req and wr_req together: treated as a store. rd_data is then undefined.
- miss = (rd_req | wr_req) & ~hit, or state != IDLE. It is combinational.
- The core holds addr, wr_data and wr_be stable while miss = 1.
- FSM states:
  - IDLE: on a request miss, select a victim: first invalid way (lowest index), else the FIFO/LRU choice. Go to SWAP_OUT if the victim is valid and dirty, else SWAP_IN. Increment miss_cnt once.
  - SWAP_OUT: mem_req = 1, mem_we = 1, mem_addr = {victim tag, set, 0}, mem_wline = victim line. On mem_ready go to SWAP_IN.
  - SWAP_IN: mem_req = 1, mem_we = 0, mem_addr = {tag, set, 0}. On mem_ready latch mem_rline into the victim way (valid = 1, dirty = 0, tag written, replacement state updated) and go to SWAP_IN_OK.
  - SWAP_IN_OK: miss stays 1 this cycle. Go to IDLE. The next cycle re-evaluates the request as a hit, which performs the load/store and increments hit_cnt.
- Miss latency (clean victim): 1 + memory latency + 1 cycles. A dirty victim adds one memory latency.
- mem_req stays high until mem_ready. mem_ready seen in IDLE or SWAP_IN_OK is ignored.
- Counters:
  - hit_cnt increments on each hit cycle in IDLE; the miss's re-evaluation after refill counts as a hit.
  - miss_cnt increments once per miss.
  - Both wrap modulo 2^32.
- Replacement:
  - FIFO: per-set round-robin pointer, advanced on each fill.
  - LRU: per-set age counters of width log2(WAY_CNT). The accessed way is set to 0; younger ways increment; the victim is the way with the maximum age.
- WAY_CNT = 1: direct-mapped; replacement logic is absent.
- Reset (asynchronous, any state including mid-refill):
  - All valid, dirty and replacement state cleared; state = IDLE.
  - mem_req = 0, mem_we = 0, mem_addr = 0, miss = 0 with no request, hit_cnt = 0, miss_cnt = 0.
  - Line data is not reset.
  - A transaction aborted by reset is dropped; memory tolerates the abandoned request.

Decomposition:
- Shared package dcache_pkg holds:
  - The FSM state enum (IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK).
  - The REPLACE_FIFO = 0 and REPLACE_LRU = 1 constants.
  - Address-field width functions.
- One sub-module, dcache_repl: per-set replacement state and victim selection.
  - Parametrised by WAY_CNT and REPLACE_POLICY.
  - Inputs: set, access_way, access_en, fill_en.
  - Output: victim_way.

Test Plan:
- Cold read miss: reset, rd_req addr 0x0000_0040, memory latency 3, mem_rline word1 = 0x1234_5678 → miss high for 5 cycles, one fill at mem_addr 0x40, then rd_data 0x1234_5678; miss_cnt = 1, hit_cnt = 1.
- Store hit, byte lane: after the previous fill, wr_req addr 0x44, wr_data 0xAABB_CCDD, wr_be 4'b0010 → no stall; a subsequent load of 0x44 returns 0x1234_CC78 (word1 unchanged elsewhere) and the line is dirty.
- Dirty eviction, WAY_CNT = 2, LRU: fill tags A and B in set 2, dirty A, touch B, then access tag C in set 2 → SWAP_OUT of A's line at A's address, then SWAP_IN of C; B remains a hit.
- FIFO policy, three conflicting tags X, Y, Z in one set with WAY_CNT = 2 → Z evicts X regardless of accesses to X in between.
- Reset during SWAP_IN (mem_req high, mem_ready not yet pulsed): deassert rst → mem_req 0 that cycle; after release the same address misses again and both counters read 0 before it.
- Counter wrap: force hit_cnt to 0xFFFF_FFFF via a hierarchical deposit, one hit → 0x0000_0000.
